// File: rtl/passcode_transmitter.sv
// passcode_transmitter: serialises a CODE_W-bit passcode MSB-first to the
// lock's data input, then watches the lock's unlock output in a bounded
// window and reports granted/denied with a one-cycle done pulse.
//
// Ports:
//   clk, asyncReset           clock (rising edge), async active-high reset
//   codeIn/codeValid/codeReady passcode handshake, accepted only in IDLE
//   serialOut, serialActive   registered serial bit, high while shifting
//   unlockIn                  lock unlock output, looked at only in RESP
//   done, granted             result pulse and held result
//   attemptCnt                attempts used (0 unless PASSCODE_RETRY_EN)
//
// Optional feature: define PASSCODE_RETRY_EN to resend the latched code
// up to MAX_RETRY extra times after a denial.
module passcode_transmitter #(
    parameter int   CODE_W    = 4,
    parameter int   BIT_DIV   = 1,
    parameter int   RESP_WAIT = 4,
    parameter int   GAP       = 2,
    parameter logic IDLE_LVL  = 1'b0,
    parameter int   MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              asyncReset,
    input  logic [CODE_W-1:0] codeIn,
    input  logic              codeValid,
    output logic              codeReady,
    output logic              serialOut,
    output logic              serialActive,
    input  logic              unlockIn,
    output logic              done,
    output logic              granted,
    output logic [1:0]        attemptCnt
);

    localparam int DW = $clog2(BIT_DIV) + 1;
    localparam int BW = $clog2(CODE_W) + 1;
    localparam int WW = $clog2(RESP_WAIT) + 1;
    localparam int GW = $clog2(GAP) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CODE_W - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(RESP_WAIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESP,
        ST_GAP
    } state_t;

    state_t            state, stateN;
    logic [CODE_W-1:0] codeReg, codeRegN;
    logic [CODE_W-1:0] shiftReg, shiftRegN;
    logic [DW-1:0]     divCnt, divCntN;
    logic [BW-1:0]     bitIdx, bitIdxN;
    logic [WW-1:0]     winCnt, winCntN;
    logic [GW-1:0]     gapCnt, gapCntN;
    logic              serialN, doneN, grantedN;

`ifdef PASSCODE_RETRY_EN
    logic [1:0] attemptReg, attemptN;
    logic       retryPending, retryN;
    assign attemptCnt = attemptReg;
`else
    logic unusedRetryCfg;
    assign unusedRetryCfg = (MAX_RETRY > 0);
    assign attemptCnt = 2'd0;
`endif

    assign codeReady    = (state == ST_IDLE);
    assign serialActive = (state == ST_SHIFT);

    always_ff @(posedge clk or posedge asyncReset) begin
        if (asyncReset) begin
            state     <= ST_IDLE;
            codeReg   <= '0;
            shiftReg  <= '0;
            divCnt    <= '0;
            bitIdx    <= '0;
            winCnt    <= '0;
            gapCnt    <= '0;
            serialOut <= IDLE_LVL;
            done      <= 1'b0;
            granted   <= 1'b0;
`ifdef PASSCODE_RETRY_EN
            attemptReg   <= 2'd0;
            retryPending <= 1'b0;
`endif
        end else begin
            state     <= stateN;
            codeReg   <= codeRegN;
            shiftReg  <= shiftRegN;
            divCnt    <= divCntN;
            bitIdx    <= bitIdxN;
            winCnt    <= winCntN;
            gapCnt    <= gapCntN;
            serialOut <= serialN;
            done      <= doneN;
            granted   <= grantedN;
`ifdef PASSCODE_RETRY_EN
            attemptReg   <= attemptN;
            retryPending <= retryN;
`endif
        end
    end

    always_comb begin
        stateN    = state;
        codeRegN  = codeReg;
        shiftRegN = shiftReg;
        divCntN   = divCnt;
        bitIdxN   = bitIdx;
        winCntN   = winCnt;
        gapCntN   = gapCnt;
        serialN   = serialOut;
        doneN     = 1'b0;
        grantedN  = granted;
`ifdef PASSCODE_RETRY_EN
        attemptN = attemptReg;
        retryN   = retryPending;
`endif
        unique case (state)
            ST_IDLE: begin
                if (codeValid) begin
                    // MSB goes out directly; the rest waits in shiftReg.
                    codeRegN  = codeIn;
                    shiftRegN = codeIn << 1;
                    serialN   = codeIn[CODE_W-1];
                    grantedN  = 1'b0;
                    divCntN   = '0;
                    bitIdxN   = '0;
                    stateN    = ST_SHIFT;
`ifdef PASSCODE_RETRY_EN
                    attemptN = 2'd1;
`endif
                end
            end
            ST_SHIFT: begin
                if (divCnt == DIV_LAST) begin
                    divCntN = '0;
                    if (bitIdx == BIT_LAST) begin
                        serialN = IDLE_LVL;
                        winCntN = '0;
                        stateN  = ST_RESP;
                    end else begin
                        bitIdxN   = bitIdx + BW'(1);
                        serialN   = shiftReg[CODE_W-1];
                        shiftRegN = shiftReg << 1;
                    end
                end else begin
                    divCntN = divCnt + DW'(1);
                end
            end
            ST_RESP: begin
                if (unlockIn) begin
                    grantedN = 1'b1;
                    doneN    = 1'b1;
                    gapCntN  = '0;
                    stateN   = ST_GAP;
`ifdef PASSCODE_RETRY_EN
                    retryN = 1'b0;
`endif
                end else if (winCnt == WIN_LAST) begin
                    grantedN = 1'b0;
                    gapCntN  = '0;
                    stateN   = ST_GAP;
`ifdef PASSCODE_RETRY_EN
                    if (int'(attemptReg) <= MAX_RETRY) begin
                        retryN = 1'b1;
                    end else begin
                        retryN = 1'b0;
                        doneN  = 1'b1;
                    end
`else
                    doneN = 1'b1;
`endif
                end else begin
                    winCntN = winCnt + WW'(1);
                end
            end
            ST_GAP: begin
                if (gapCnt == GAP_LAST) begin
`ifdef PASSCODE_RETRY_EN
                    if (retryPending) begin
                        // Resend: reload from the latched code.
                        shiftRegN = codeReg << 1;
                        serialN   = codeReg[CODE_W-1];
                        divCntN   = '0;
                        bitIdxN   = '0;
                        retryN    = 1'b0;
                        attemptN  = (attemptReg == 2'd3) ?
                                    2'd3 : attemptReg + 2'd1;
                        stateN    = ST_SHIFT;
                    end else begin
                        stateN = ST_IDLE;
                    end
`else
                    stateN = ST_IDLE;
`endif
                end else begin
                    gapCntN = gapCnt + GW'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_passcode_transmitter.sv
// tb_passcode_transmitter: random and directed transactions checked
// cycle by cycle against a transaction-level reference model.
module tb_passcode_transmitter;

    localparam int CW = 4;
    localparam int BD = 3;
    localparam int RW = 4;
    localparam int GP = 2;
    localparam int MR = 2;
`ifdef PASSCODE_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          asyncReset;
    logic [CW-1:0] codeIn;
    logic          codeValid;
    logic          codeReady;
    logic          serialOut;
    logic          serialActive;
    logic          unlockIn;
    logic          done;
    logic          granted;
    logic [1:0]    attemptCnt;

    always #5 clk = ~clk;

    passcode_transmitter #(
        .CODE_W(CW), .BIT_DIV(BD), .RESP_WAIT(RW),
        .GAP(GP), .IDLE_LVL(1'b0), .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .asyncReset(asyncReset),
        .codeIn(codeIn),
        .codeValid(codeValid),
        .codeReady(codeReady),
        .serialOut(serialOut),
        .serialActive(serialActive),
        .unlockIn(unlockIn),
        .done(done),
        .granted(granted),
        .attemptCnt(attemptCnt)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       ser;
        logic       act;
        logic       rdy;
        logic       dn;
        logic       gr;
        logic [1:0] att;
    } exp_t;

    exp_t expQ[$];
    bit   unlPat[256];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     tag, got, want, $time);
        end
    endtask

    // Expected per-cycle outputs, cycle 1 = first cycle after accept.
    function automatic void buildModel(input logic [CW-1:0] c);
        int t = 1;
        int a = 1;
        bit g = 0;
        bit fin = 0;
        logic [1:0] att = 2'd0;
        expQ.delete();
        while (!fin) begin
            att = RETRY ? ((a > 3) ? 2'd3 : 2'(a)) : 2'd0;
            for (int k = 0; k < CW * BD; k++) begin
                expQ.push_back('{ser: c[CW-1-k/BD], act: 1'b1,
                    rdy: 1'b0, dn: 1'b0, gr: 1'b0, att: att});
                t++;
            end
            g = 0;
            for (int j = 0; j < RW; j++) begin
                expQ.push_back('{ser: 1'b0, act: 1'b0, rdy: 1'b0,
                    dn: 1'b0, gr: 1'b0, att: att});
                t++;
                if (unlPat[t-1]) begin
                    g = 1;
                    break;
                end
            end
            fin = g || !RETRY || (a > MR);
            for (int j = 0; j < GP; j++) begin
                expQ.push_back('{ser: 1'b0, act: 1'b0, rdy: 1'b0,
                    dn: fin && (j == 0), gr: g, att: att});
                t++;
            end
            a++;
        end
        expQ.push_back('{ser: 1'b0, act: 1'b0, rdy: 1'b1,
            dn: 1'b0, gr: g, att: att});
    endfunction

    // 0: random, 1: deny with unlock high during first frame's shift,
    // 2: grant on second response cycle of first frame.
    task automatic setPattern(input int mode);
        for (int i = 0; i < 256; i++) begin
            unique case (mode)
                0: unlPat[i] = ($urandom_range(0, 3) == 0);
                1: unlPat[i] = (i >= 1) && (i <= CW * BD);
                default: unlPat[i] = (i == CW * BD + 2);
            endcase
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!codeReady && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("readyWait", codeReady, 1);
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic runTxn(input logic [CW-1:0] c, input int mode);
        exp_t e;
        waitReady();
        setPattern(mode);
        buildModel(c);
        codeValid = 1'b1;
        codeIn    = c;
        unlockIn  = 1'($urandom);
        @(posedge clk);
        #1;
        foreach (expQ[i]) begin
            e = expQ[i];
            unlockIn = unlPat[i+1];
            if (!e.rdy) begin
                codeValid = 1'($urandom);
                codeIn    = CW'($urandom);
            end else begin
                codeValid = 1'b0;
            end
            check("serialOut", serialOut, e.ser);
            check("serialActive", serialActive, e.act);
            check("codeReady", codeReady, e.rdy);
            check("done", done, e.dn);
            check("granted", granted, e.gr);
            check("attemptCnt", attemptCnt, e.att);
            if (i != expQ.size() - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, codeReady, 1);
        check({tag, "_serial"}, serialOut, 0);
        check({tag, "_active"}, serialActive, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_granted"}, granted, 0);
        check({tag, "_attempt"}, attemptCnt, 0);
    endtask

    initial begin
        bit doneSeen;
        logic [CW-1:0] rc;
        asyncReset = 1'b1;
        codeIn     = '0;
        codeValid  = 1'b0;
        unlockIn   = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("rst");
        asyncReset = 1'b0;

        runTxn(4'b0101, 2);
        runTxn(4'b1001, 1);
        runTxn(4'b0110, 2);
        for (int n = 0; n < 25; n++) begin
            rc = CW'($urandom);
            runTxn(rc, 0);
        end

        // Reset in the middle of bit 2 of a frame.
        waitReady();
        codeValid = 1'b1;
        codeIn    = 4'b1011;
        @(posedge clk);
        #1;
        codeValid = 1'b0;
        repeat (2 * BD) @(posedge clk);
        #1;
        check("midActive", serialActive, 1);
        check("midBit2", serialOut, 1);
        #2;
        asyncReset = 1'b1;
        #1;
        checkResetOutputs("midRst");
        @(posedge clk);
        #1;
        asyncReset = 1'b0;
        doneSeen = 0;
        for (int n = 0; n < 20; n++) begin
            doneSeen = doneSeen | done;
            @(posedge clk);
            #1;
        end
        check("noDoneAfterRst", doneSeen, 0);
        check("readyAfterRst", codeReady, 1);

        runTxn(4'b1110, 2);
        runTxn(4'b0011, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
